fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL use one clock, wclk; reset wrst SHALL be asynchronous and active-high.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter DATA_WIDTH, default 8, SHALL set the data word width.
REQ-004 Parameter BURST, default 4, SHALL set the maximum number of beats per grant (1..16).
REQ-005 Port wclk  input  1  SHALL be the write-domain clock.
REQ-006 Port wrst  input  1  SHALL be the asynchronous active-high reset.
REQ-007 Port req_valid  input  NREQ  SHALL carry the per-requester data-valid flags.
REQ-008 Port req_data  input  NREQ*DATA_WIDTH  SHALL carry the per-requester words, with requester i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_ready  output  NREQ  SHALL carry the per-requester accept strobes.
REQ-010 Port fifo_full  input  1  SHALL be the full flag from the FIFO write side.
REQ-011 Port fifo_w_en  output  1  SHALL be the FIFO write enable.
REQ-012 Port fifo_data_in  output  DATA_WIDTH  SHALL be the FIFO write data.
REQ-013 Port grant_id  output  clog2(NREQ)  SHALL be the index of the current grant holder.
REQ-014 Port busy  output  1  SHALL be high while a grant is held.

Function
REQ-015 The FSM SHALL have two states: IDLE (no grant) and BUSY (grant held by grant_id).
REQ-016 In IDLE with any req_valid high, the block SHALL pick the first valid requester, searching round-robin from last_grant+1 modulo NREQ, register it into grant_id, clear the beat count and enter BUSY next cycle. This gives a one-cycle arbitration bubble.
REQ-017 In IDLE with no req_valid high, the block SHALL stay in IDLE and hold grant_id.
REQ-018 In BUSY, req_ready[grant_id] SHALL equal !fifo_full combinationally; all other req_ready bits SHALL be 0.
REQ-019 In BUSY, fifo_w_en SHALL equal req_valid[grant_id] & !fifo_full, and fifo_data_in SHALL equal the req_data slice of grant_id.
REQ-020 In IDLE, req_ready SHALL be 0, fifo_w_en SHALL be 0 and fifo_data_in SHALL be 0.
REQ-021 A beat SHALL be a cycle with fifo_w_en high; each beat SHALL increment the beat count by 1.
REQ-022 On the beat that brings the count to BURST, the block SHALL enter IDLE at the next edge and set last_grant to grant_id.
REQ-023 In BUSY with req_valid[grant_id] low, the block SHALL enter IDLE at the next edge and set last_grant to grant_id (early release, including while fifo_full is high).
REQ-024 While fifo_full is high and req_valid[grant_id] is high, the block SHALL hold the grant, the beat count and the state, and no beat SHALL occur.
REQ-025 If fifo_full is high in the cycle that would be the final beat, no beat SHALL occur and the grant SHALL persist until a beat completes.
REQ-026 Changes to req_valid of non-holders SHALL have no effect until the next IDLE cycle.
REQ-027 The beat counter SHALL be clog2(BURST)+1 bits wide and SHALL never exceed BURST.
REQ-028 busy SHALL be high exactly when the state is BUSY.

Reset
REQ-029 While wrst is high, the block SHALL force state IDLE, grant_id 0, last_grant NREQ-1 (requester 0 has first priority), beat count 0, busy 0, req_ready 0, fifo_w_en 0 and fifo_data_in 0.
REQ-030 Reset asserted mid-burst SHALL drop fifo_w_en immediately; after release, the first grant SHALL follow REQ-029 priority.
REQ-031 After wrst deasserts, the block SHALL start arbitrating on the first wclk edge.

Verification
REQ-032 Reset check: pulse wrst with all req_valid high -> busy=0, fifo_w_en=0, req_ready=0 while reset is high; first grant_id=0 after release.
REQ-033 Single requester: req2 streams 0xA0..0xA5 with fifo_full=0 -> FIFO receives A0..A3 on 4 consecutive cycles, then 1 IDLE cycle, then A4, A5; grant_id=2 throughout.
REQ-034 Fairness: all four requesters valid continuously, BURST=4 -> grant sequence 0,1,2,3,0; each grant gives exactly 4 beats separated by one bubble.
REQ-035 Backpressure: fifo_full high for 3 cycles after beat 2 of req1 -> fifo_w_en=0 and req_ready[1]=0 for 3 cycles, count held at 2; beats 3 and 4 follow, then release.
REQ-036 Early release: req3 deasserts valid after 2 beats while req0 is valid -> IDLE next cycle, then grant_id=0; req3 is not re-granted before req0.
REQ-037 Reset mid-burst: wrst asserted after beat 1 of req2 -> fifo_w_en=0 at once; after release with req2 and req0 valid, grant_id=0 first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time access to a FIFO
// write port for up to BURST beats, with a one-cycle arbitration bubble.
module fifo_wr_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST      = 4
) (
    input  logic                       wclk,
    input  logic                       wrst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_w_en,
    output logic [DATA_WIDTH-1:0]      fifo_data_in,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       busy
);

    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant_id;
    logic [GW-1:0]   r_last_grant;
    logic [CW-1:0]   r_cnt;

    state_t          w_state_nxt;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   w_last_nxt;
    logic [CW-1:0]   w_cnt_nxt;

    logic            w_found;
    logic [GW-1:0]   w_pick;
    int              w_idx;
    logic            w_hold_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic            w_busy;
    logic            w_beat;

    // Search starts just after the previous holder so every requester gets a turn
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(w_idx);
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_busy       = (r_state == BUSY);
    assign w_hold_valid = req_valid[r_grant_id];
    assign w_beat       = w_busy & w_hold_valid & ~fifo_full;

    assign busy         = w_busy;
    assign fifo_w_en    = w_beat;
    assign fifo_data_in = w_busy ? w_data : '0;
    assign grant_id     = r_grant_id;

    always_comb begin
        req_ready = '0;
        if (w_busy) begin
            req_ready[r_grant_id] = ~fifo_full;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            BUSY: begin
                // Holder dropping valid releases the grant even under backpressure
                if (!w_hold_valid) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant_id;
                end else if (w_beat) begin
                    if (r_cnt == CW'(BURST - 1)) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_grant_id;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NREQ - 1);
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues feed the DUT and a
// negedge monitor checks each FIFO write against a timed scoreboard.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_w_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;

    fifo_wr_arbiter #(
        .NREQ(4),
        .DATA_WIDTH(8),
        .BURST(4)
    ) dut (
        .wclk(wclk),
        .wrst(wrst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .fifo_full(fifo_full),
        .fifo_w_en(fifo_w_en),
        .fifo_data_in(fifo_data_in),
        .grant_id(grant_id),
        .busy(busy)
    );

    typedef struct packed {
        int         cyc;
        logic [1:0] g;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       m_e;
    exp_t       s_e;
    int         n_cmp;
    int         n_err;
    int         cyc;
    int         n0;
    logic [7:0] mem [4][32];
    int         wp [4];
    int         rp [4];
    logic [3:0] acc;
    logic [7:0] base [4];

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial cyc = 0;
    always @(posedge wclk) cyc <= cyc + 1;

    initial begin
        #50000;
        $display("FAIL watchdog: run did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge wclk) begin
        if (fifo_w_en === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL write: unexpected cyc %0d gid %0d data %0h",
                         cyc, grant_id, fifo_data_in);
            end else begin
                m_e = exp_q.pop_front();
                if (m_e.cyc != cyc || m_e.g !== grant_id || m_e.d !== fifo_data_in) begin
                    n_err++;
                    $display("FAIL write: got cyc %0d gid %0d data %0h want cyc %0d gid %0d data %0h",
                             cyc, grant_id, fifo_data_in, m_e.cyc, m_e.g, m_e.d);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (wp[i] != rp[i]) begin
                req_valid[i]      = 1'b1;
                req_data[i*8 +: 8] = mem[i][rp[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d);
        mem[i][wp[i]] = d;
        wp[i]++;
    endtask

    task automatic expw(input int c, input int g, input logic [7:0] d);
        s_e.cyc = c;
        s_e.g   = 2'(g);
        s_e.d   = d;
        exp_q.push_back(s_e);
    endtask

    // Requesters pop their head word on any cycle it was accepted
    task automatic step();
        @(negedge wclk);
        acc = req_ready & req_valid;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) rp[i]++;
        end
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 4; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        base[0] = 8'hB0;
        base[1] = 8'hC0;
        base[2] = 8'hD0;
        base[3] = 8'hE0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        wrst      = 1'b1;

        // reset with every requester valid
        for (int i = 0; i < 4; i++) push(i, 8'(8'h10 + i));
        drive();
        steps(2);
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wen", 32'(fifo_w_en), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'h0);
        chk("rst_data", 32'(fifo_data_in), 32'h0);
        step();
        wrst = 1'b0;
        n0 = cyc;
        for (int g = 0; g < 4; g++) expw(n0 + 1 + 3*g, g, 8'(8'h10 + g));
        steps(14);

        // fairness: grants 0,1,2,3,0 with four beats each
        for (int k = 0; k < 8; k++) push(0, 8'(8'hB0 + k));
        for (int i = 1; i < 4; i++) begin
            for (int k = 0; k < 4; k++) push(i, 8'(base[i] + 8'(k)));
        end
        drive();
        n0 = cyc;
        for (int gi = 0; gi < 5; gi++) begin
            for (int k = 0; k < 4; k++) begin
                expw(n0 + 1 + 5*gi + k, gi % 4,
                     (gi == 4) ? 8'(8'hB4 + k) : 8'(base[gi] + 8'(k)));
            end
        end
        steps(27);

        // single requester: burst of four, bubble, then the rest
        for (int k = 0; k < 6; k++) push(2, 8'(8'hA0 + k));
        drive();
        n0 = cyc;
        for (int k = 0; k < 4; k++) expw(n0 + 1 + k, 2, 8'(8'hA0 + k));
        expw(n0 + 6, 2, 8'hA4);
        expw(n0 + 7, 2, 8'hA5);
        steps(10);

        // backpressure after beat 2 of requester 1
        for (int k = 0; k < 4; k++) push(1, 8'(8'h50 + k));
        drive();
        n0 = cyc;
        expw(n0 + 1, 1, 8'h50);
        expw(n0 + 2, 1, 8'h51);
        expw(n0 + 6, 1, 8'h52);
        expw(n0 + 7, 1, 8'h53);
        steps(2);
        for (int j = 0; j < 3; j++) begin
            step();
            fifo_full = 1'b1;
            #3;
            chk("bp_wen", 32'(fifo_w_en), 32'h0);
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
        end
        step();
        fifo_full = 1'b0;
        steps(6);

        // early release of requester 3; requester 0 goes next
        push(3, 8'h60);
        push(3, 8'h61);
        push(0, 8'h70);
        push(0, 8'h71);
        drive();
        n0 = cyc;
        expw(n0 + 1, 3, 8'h60);
        expw(n0 + 2, 3, 8'h61);
        expw(n0 + 5, 0, 8'h70);
        expw(n0 + 6, 0, 8'h71);
        expw(n0 + 9, 3, 8'h62);
        expw(n0 + 10, 3, 8'h63);
        steps(4);
        #3;
        chk("er_idle", 32'(busy), 32'h0);
        push(3, 8'h62);
        push(3, 8'h63);
        drive();
        steps(12);

        // reset in the middle of a burst
        for (int k = 0; k < 4; k++) push(2, 8'(8'h80 + k));
        drive();
        n0 = cyc;
        expw(n0 + 1, 2, 8'h80);
        step();
        step();
        wrst = 1'b1;
        push(0, 8'h90);
        drive();
        #3;
        chk("mr_wen", 32'(fifo_w_en), 32'h0);
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_ready", 32'(req_ready), 32'h0);
        steps(2);
        wrst = 1'b0;
        expw(n0 + 5, 0, 8'h90);
        expw(n0 + 8, 2, 8'h81);
        expw(n0 + 9, 2, 8'h82);
        expw(n0 + 10, 2, 8'h83);
        steps(12);

        // full on what would be the final beat
        for (int k = 0; k < 4; k++) push(1, 8'(8'hC0 + k));
        drive();
        n0 = cyc;
        expw(n0 + 1, 1, 8'hC0);
        expw(n0 + 2, 1, 8'hC1);
        expw(n0 + 3, 1, 8'hC2);
        expw(n0 + 5, 1, 8'hC3);
        steps(4);
        fifo_full = 1'b1;
        #3;
        chk("fb_wen", 32'(fifo_w_en), 32'h0);
        chk("fb_busy", 32'(busy), 32'h1);
        chk("fb_gid", 32'(grant_id), 32'h1);
        step();
        fifo_full = 1'b0;
        step();
        #3;
        chk("fb_idle", 32'(busy), 32'h0);
        steps(4);

        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
